sample_reader: RTL

Downstream readout stage for the sampler. Once a capture completes, it reads the 2^SAMPLE_DEPTH-entry circular sample memory in chronological order, oldest sample first. Reading starts at the oldest sample, which is located using the trigger offset the sampler latched. Each sample goes out as a byte on a valid/ready stream, preceded by a sync header byte; the stream feeds the host link (UART transmitter). The block uses the sample memory's read port while the sampler is idle.

---
 rtl/sample_reader_if.sv | 30 +++
 rtl/sample_reader.sv | 122 ++++++++++++
 2 files changed

// File: rtl/sample_reader_if.sv
// Readout bus of sample_reader: synchronous RAM read port plus the valid/ready byte stream.
// master = the reader, slave = the RAM/stream-consumer side.
interface sample_reader_if #(
  parameter int unsigned SAMPLE_DEPTH = 8
);
  logic                    mem_rd_en;
  logic [SAMPLE_DEPTH-1:0] mem_rd_addr;
  logic [7:0]              mem_rd_data;
  logic [7:0]              out_data;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output mem_rd_en,
    output mem_rd_addr,
    input  mem_rd_data,
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  mem_rd_en,
    input  mem_rd_addr,
    output mem_rd_data,
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/sample_reader.sv
// Reads the circular sample memory oldest-first after a capture and streams it out
// as bytes behind a sync header, one RAM read per byte.
module sample_reader #(
  parameter int unsigned SAMPLE_DEPTH = 8,
  parameter int unsigned PRE_TRIG     = 1 << (SAMPLE_DEPTH - 1),
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic                    clk_50mhz,
  input  logic                    reset,
  input  logic                    start,
  input  logic [SAMPLE_DEPTH-1:0] offset,
  output logic                    busy,
  output logic                    done,
  sample_reader_if.master         bus
);

  localparam int unsigned AW = SAMPLE_DEPTH;
  localparam logic [AW-1:0] PRE_OFS  = AW'(PRE_TRIG);
  localparam logic [AW-1:0] CNT_LAST = {AW{1'b1}};
  localparam logic [AW-1:0] ADDR_ONE = AW'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HEADER = 3'd1,
    S_READ   = 3'd2,
    S_LATCH  = 3'd3,
    S_SEND   = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  state_e        state_q;
  logic [AW-1:0] cnt_q;
  logic [AW-1:0] addr_q;
  logic          rd_en_q;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          busy_q;
  logic          done_q;

  logic hs;
  assign hs = valid_q & bus.out_ready;

  // Readout FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk_50mhz or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rd_en_q <= 1'b0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            addr_q  <= offset + PRE_OFS;
            data_q  <= SYNC_BYTE;
            valid_q <= 1'b1;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_HEADER;
          end
        end
        S_HEADER: begin
          if (hs) begin
            valid_q <= 1'b0;
            rd_en_q <= 1'b1;
            state_q <= S_READ;
          end
        end
        S_READ: begin
          rd_en_q <= 1'b0;
          state_q <= S_LATCH;
        end
        S_LATCH: begin
          data_q  <= bus.mem_rd_data;
          valid_q <= 1'b1;
          state_q <= S_SEND;
        end
        S_SEND: begin
          if (hs) begin
            valid_q <= 1'b0;
            if (cnt_q == CNT_LAST) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_DONE;
            end else begin
              cnt_q   <= cnt_q + ADDR_ONE;
              addr_q  <= addr_q + ADDR_ONE;
              rd_en_q <= 1'b1;
              state_q <= S_READ;
            end
          end
        end
        S_DONE: begin
          // Held until the sampler drops its done level.
          if (!start) begin
            done_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          rd_en_q <= 1'b0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign bus.mem_rd_en   = rd_en_q;
  assign bus.mem_rd_addr = addr_q;
  assign bus.out_data    = data_q;
  assign bus.out_valid   = valid_q;

endmodule
